// File: rtl/i2s_tx_stream.sv
// I2S / left-justified stereo transmitter with a one-pair holding buffer; I2S_TX_UNDERRUN_CNT_EN adds underrun_cnt.
// Latency: an accepted pair is sent in the frame starting after the accept clk (one extra frame if hold was full).
// Backpressure: s_ready = !hold_full; hold frees on the frame-start clk, so ready reasserts from the next clk.
module i2s_tx_stream #(
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              mode_lj,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              bclk,
  output logic              lrclk,
  output logic              dacdat,
  output logic              frame_start,
  output logic              underrun,
`ifdef I2S_TX_UNDERRUN_CNT_EN
  output logic [15:0]       underrun_cnt,
`endif
  input  logic              underrun_clr
);
  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              bclk_q, bclk_d, lrclk_q, lrclk_d, dacdat_q, dacdat_d;
  logic              frame_start_q, frame_start_d, run_q, run_d, mode_q, mode_d;
  logic              underrun_q, underrun_d, hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0]       underrun_cnt_q, underrun_cnt_d;
`endif

  logic              div_tc, fall, fstart, mode_eff, slot_r, in_data, ur_set;
  logic [BIT_W-1:0]  nxt_bit, pos, off, rel;
  logic [DATA_W-1:0] src_l, src_r;

  assign div_tc = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    div_d         = div_q;
    bit_cnt_d     = bit_cnt_q;
    bclk_d        = bclk_q;
    lrclk_d       = lrclk_q;
    dacdat_d      = dacdat_q;
    frame_start_d = 1'b0;
    run_d         = run_q;
    mode_d        = mode_q;
    underrun_d    = underrun_q;
    hold_full_d   = hold_full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    sh_l_d        = sh_l_q;
    sh_r_d        = sh_r_q;
    fall          = 1'b0;
    fstart        = 1'b0;
    nxt_bit       = bit_cnt_q;
    mode_eff      = mode_q;
    slot_r        = 1'b0;
    pos           = '0;
    off           = '0;
    rel           = '0;
    in_data       = 1'b0;
    src_l         = sh_l_q;
    src_r         = sh_r_q;

    if (!enable) begin
      div_d     = '0;
      bit_cnt_d = '0;
      bclk_d    = 1'b0;
      lrclk_d   = 1'b0;
      dacdat_d  = 1'b0;
      run_d     = 1'b0;
    end else begin
      if (div_tc) begin
        div_d  = '0;
        bclk_d = ~bclk_q;
        fall   = bclk_q;
      end else begin
        div_d = div_q + 1'b1;
      end

      if (fall) begin
        // The first fall after enable always opens a fresh frame.
        nxt_bit = (!run_q || bit_cnt_q == BIT_W'(FRAME_W - 1)) ? '0 : bit_cnt_q + 1'b1;
        fstart  = (nxt_bit == '0);
        if (fstart) begin
          mode_eff = mode_lj;
          src_l    = hold_full_q ? hold_l_q : '0;
          src_r    = hold_full_q ? hold_r_q : '0;
        end
        slot_r  = (nxt_bit >= BIT_W'(SLOT_W));
        pos     = slot_r ? nxt_bit - BIT_W'(SLOT_W) : nxt_bit;
        off     = mode_eff ? '0 : BIT_W'(1);
        rel     = pos - off;
        in_data = (pos >= off) && (rel < BIT_W'(DATA_W));

        run_d         = 1'b1;
        bit_cnt_d     = nxt_bit;
        mode_d        = mode_eff;
        frame_start_d = fstart;
        lrclk_d       = mode_eff ? ~slot_r : slot_r;
        dacdat_d      = 1'b0;
        sh_l_d        = src_l;
        sh_r_d        = src_r;
        if (in_data) begin
          if (slot_r) begin
            dacdat_d = src_r[DATA_W-1];
            sh_r_d   = {src_r[DATA_W-2:0], 1'b0};
          end else begin
            dacdat_d = src_l[DATA_W-1];
            sh_l_d   = {src_l[DATA_W-2:0], 1'b0};
          end
        end
      end
    end

    // Frame start checks the registered hold state, so a same-clk transfer waits a frame.
    ur_set = fstart && !hold_full_q;
    if (fstart && hold_full_q) hold_full_d = 1'b0;
    if (s_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_l_d    = s_left;
      hold_r_d    = s_right;
    end

    if (ur_set)            underrun_d = 1'b1;
    else if (underrun_clr) underrun_d = 1'b0;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    underrun_cnt_d = underrun_clr ? 16'd0 : underrun_cnt_q;
    if (ur_set) begin
      if (underrun_clr)                   underrun_cnt_d = 16'd1;
      else if (underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      bit_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      dacdat_q      <= 1'b0;
      frame_start_q <= 1'b0;
      run_q         <= 1'b0;
      mode_q        <= 1'b0;
      underrun_q    <= 1'b0;
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      sh_l_q        <= '0;
      sh_r_q        <= '0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
      underrun_cnt_q <= 16'd0;
`endif
    end else begin
      div_q         <= div_d;
      bit_cnt_q     <= bit_cnt_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      dacdat_q      <= dacdat_d;
      frame_start_q <= frame_start_d;
      run_q         <= run_d;
      mode_q        <= mode_d;
      underrun_q    <= underrun_d;
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      sh_l_q        <= sh_l_d;
      sh_r_q        <= sh_r_d;
`ifdef I2S_TX_UNDERRUN_CNT_EN
      underrun_cnt_q <= underrun_cnt_d;
`endif
    end
  end

  assign s_ready     = ~hold_full_q;
  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign dacdat      = dacdat_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Bench for i2s_tx_stream: accepted pairs are queued with their accept edge; a monitor rebuilds each frame
// from the serial pins and compares it with a frame computed from the bit-placement rules.
`timescale 1ns/1ps
module tb_i2s_tx_stream;
  localparam int DATA_W  = 24;
  localparam int SLOT_W  = 32;
  localparam int CLK_DIV = 2;
  localparam int FRAME_W = 2 * SLOT_W;

  logic              clk = 1'b0;
  logic              rst_n, enable, mode_lj, s_valid, s_ready, underrun_clr;
  logic              bclk, lrclk, dacdat, frame_start, underrun;
  logic [DATA_W-1:0] s_left, s_right;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0]       underrun_cnt;
  int                model_cnt = 0;
`endif

  i2s_tx_stream #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode_lj(mode_lj),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .bclk(bclk), .lrclk(lrclk), .dacdat(dacdat), .frame_start(frame_start),
    .underrun(underrun),
`ifdef I2S_TX_UNDERRUN_CNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
    int                stamp;
  } pair_t;

  pair_t acc_q[$];
  int    edge_n = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    frames_done = 0;
  bit    model_ur = 1'b0;

  always @(posedge clk) edge_n++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  logic [63:0]       got_dat, got_lr, exp_dat, exp_lr;
  logic [DATA_W-1:0] mw;
  pair_t             cur_p;
  int                idx = 0, t0 = 0, mslot, mk;
  bit                collecting = 1'b0, bclk_prev = 1'b0, cur_mode;

  always @(negedge clk) begin
    if (frame_start) begin
      collecting = 1'b1;
      idx        = 0;
      cur_mode   = mode_lj;
      if (acc_q.size() > 0 && acc_q[0].stamp < edge_n) begin
        cur_p = acc_q.pop_front();
      end else begin
        cur_p.l  = '0;
        cur_p.r  = '0;
        model_ur = 1'b1;
`ifdef I2S_TX_UNDERRUN_CNT_EN
        if (model_cnt < 65535) model_cnt++;
`endif
      end
      for (int i = 0; i < FRAME_W; i++) begin
        mslot = i / SLOT_W;
        mk    = (i % SLOT_W) - (cur_mode ? 0 : 1);
        mw    = (mslot == 1) ? cur_p.r : cur_p.l;
        exp_dat[i] = (mk >= 0 && mk < DATA_W) ? mw[DATA_W-1-mk] : 1'b0;
        exp_lr[i]  = cur_mode ? (mslot == 0) : (mslot == 1);
      end
    end
    if (collecting && bclk && !bclk_prev) begin
      got_dat[idx] = dacdat;
      got_lr[idx]  = lrclk;
      if (idx == 0) t0 = edge_n;
      if (idx == FRAME_W - 1) begin
        check("frame_dacdat", got_dat, exp_dat);
        check("frame_lrclk", got_lr, exp_lr);
        check("frame_bclk_period", edge_n - t0, 63 * 2 * CLK_DIV);
        check("frame_underrun_flag", underrun, model_ur);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("frame_underrun_cnt", underrun_cnt, model_cnt);
`endif
        collecting = 1'b0;
        frames_done++;
      end
      idx++;
    end
    bclk_prev = bclk;
  end

  // Stimulus helpers
  task automatic push(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    pair_t p;
    int    waited = 0;
    @(negedge clk);
    s_valid = 1'b1; s_left = l; s_right = r;
    while (!s_ready && waited <= 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: s_ready still %b after %0d clks, required 1", s_ready, waited);
    end else begin
      if (waited > 0) check("ready_returns_with_frame_start", frame_start, 1'b1);
      p.l = l; p.r = r; p.stamp = edge_n + 1;
      acc_q.push_back(p);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idx(input int n);
    int c = 0;
    while (!(collecting && idx >= n) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (!(collecting && idx >= n)) begin
      n_checks++; n_fail++;
      $display("FAIL wait_bit_timeout: bit index %0d, required %0d", idx, n);
    end
  endtask

  task automatic wait_frames(input int n);
    int target = frames_done + n;
    int c = 0;
    while (frames_done < target && c < 700 * n) begin
      @(negedge clk);
      c++;
    end
    if (frames_done < target) begin
      n_checks++; n_fail++;
      $display("FAIL wait_frame_timeout: frames %0d, required %0d", frames_done, target);
    end
  endtask

  task automatic clear_ur();
    wait_idx(10);
    underrun_clr = 1'b1;
    model_ur = 1'b0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    model_cnt = 0;
`endif
    @(negedge clk);
    underrun_clr = 1'b0;
    check("underrun_cleared", underrun, 1'b0);
  endtask

  task automatic disable_mid_frame();
    wait_idx(10);
    enable = 1'b0;
    @(negedge clk);
    check("dis_bclk", bclk, 1'b0);
    check("dis_lrclk", lrclk, 1'b0);
    check("dis_dacdat", dacdat, 1'b0);
    check("dis_s_ready", s_ready, acc_q.size() == 0);
  endtask

  initial begin
    int c, g;
    rst_n = 1'b0; enable = 1'b0; mode_lj = 1'b0; s_valid = 1'b0;
    s_left = '0; s_right = '0; underrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bclk", bclk, 1'b0);
    check("rst_lrclk", lrclk, 1'b0);
    check("rst_dacdat", dacdat, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_s_ready", s_ready, 1'b1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("rst_underrun_cnt", underrun_cnt, 16'd0);
`endif
    rst_n = 1'b1;

    // I2S with the reference pair, then an empty frame
    push(24'h800001, 24'h7FFFFE);
    enable = 1'b1;
    wait_frames(1);
    wait_frames(1);
    check("underrun_sticky", underrun, 1'b1);
    clear_ur();

    // Random pairs, mostly back-to-back, some long gaps
    for (int n = 0; n < 8; n++) begin
      push(DATA_W'($urandom), DATA_W'($urandom));
      g = ($urandom_range(0, 3) == 0) ? 300 : $urandom_range(0, 5);
      repeat (g) @(negedge clk);
    end
    wait_frames(2);
    clear_ur();

    // Left-justified
    disable_mid_frame();
    mode_lj = 1'b1;
    push(24'h800001, 24'h7FFFFE);
    enable = 1'b1;
    wait_frames(1);
    for (int n = 0; n < 4; n++) push(DATA_W'($urandom), DATA_W'($urandom));
    wait_frames(2);

    // Disable with a pair held, then resume
    wait_idx(5);
    push(DATA_W'($urandom), DATA_W'($urandom));
    disable_mid_frame();
    repeat (40) @(negedge clk);
    check("held_while_disabled", s_ready, acc_q.size() == 0);
    enable = 1'b1;
    wait_frames(1);

    // Reset mid-frame
    push(DATA_W'($urandom), DATA_W'($urandom));
    wait_idx(40);
    rst_n = 1'b0;
    #1;
    check("arst_bclk", bclk, 1'b0);
    check("arst_lrclk", lrclk, 1'b0);
    check("arst_dacdat", dacdat, 1'b0);
    check("arst_underrun", underrun, 1'b0);
    check("arst_s_ready", s_ready, 1'b1);
    acc_q.delete();
    model_ur = 1'b0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    model_cnt = 0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!frame_start && c < 100);
    check("first_frame_delay", c, 2 * CLK_DIV);
    wait_frames(1);
    push(DATA_W'($urandom), DATA_W'($urandom));
    wait_frames(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
